rnm_inverter_bank: RTL and testbench

- N-channel, clocked real-number-model (RNM) inverter bank: each channel compares a real input against a hysteresis window, applies an inertial propagation delay counted in clock cycles, then slews its real output linearly to the opposite rail.
- Successor to the single continuous-assign RNM inverter: adds channel count, hysteresis, TPHL/TPLH delay, slew ramps, glitch rejection and transition counting.
- Drives mixed-signal testbench loads and digital monitors.

---
 rtl/rnm_inverter_bank_pkg.sv | 21 ++
 rtl/rnm_inv_channel.sv | 113 +++++++++++
 rtl/rnm_inverter_bank.sv | 43 ++++
 tb/tb_rnm_inverter_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rnm_inverter_bank_pkg.sv
// Shared types, default rails/thresholds and the slew-step helper for the
// clocked RNM inverter bank.
package rnm_inv_pkg;

  typedef enum logic [1:0] {STEADY, DELAY, RAMP} rnm_inv_st_e;

  localparam real RNM_VDD  = 1.8;
  localparam real RNM_VSS  = 0.0;
  localparam real RNM_VTH  = 0.9;
  localparam real RNM_VHYS = 0.1;
  // Absorbs accumulated rounding so a ramp lands on the rail in exactly T steps.
  localparam real RNM_EPS  = 1.0e-9;

  function automatic real rnm_next_vout(input real v, input logic tgt,
                                        input real step, input real vdd,
                                        input real vss);
    if (tgt) return (v + step >= vdd - RNM_EPS) ? vdd : v + step;
    else     return (v - step <= vss + RNM_EPS) ? vss : v - step;
  endfunction

endpackage

// File: rtl/rnm_inv_channel.sv
// One inverter channel: hysteretic compare, inertial delay, linear slew to
// the target rail, saturating count of completed transitions.
module rnm_inv_channel
  import rnm_inv_pkg::*;
#(
  parameter real VDD       = RNM_VDD,
  parameter real VSS       = RNM_VSS,
  parameter real VTH       = RNM_VTH,
  parameter real VHYS      = RNM_VHYS,
  parameter int  TPHL_CYC  = 7,
  parameter int  TPLH_CYC  = 2,
  parameter int  TFALL_CYC = 6,
  parameter int  TRISE_CYC = 7,
  parameter int  CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  real              i_vin,
  output real              o_vout,
  output logic             o_dout,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_edge_cnt
);

  localparam int  DLY_MAX = (TPHL_CYC > TPLH_CYC) ? TPHL_CYC : TPLH_CYC;
  localparam int  DLY_W   = $clog2(DLY_MAX + 2);
  localparam real STEP_F  = (VDD - VSS) / real'(TFALL_CYC);
  localparam real STEP_R  = (VDD - VSS) / real'(TRISE_CYC);
  localparam real V_HI    = VTH + VHYS / 2.0;
  localparam real V_LO    = VTH - VHYS / 2.0;

  rnm_inv_st_e      r_st,  w_st;
  logic             r_tgt, w_tgt;
  logic             r_dout, w_dout;
  logic [DLY_W-1:0] r_dly, w_dly, w_ld;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  real              r_vout, w_vout;
  logic             w_want, w_go;

  always_comb begin
    w_st   = r_st;
    w_tgt  = r_tgt;
    w_dout = r_dout;
    w_dly  = r_dly;
    w_cnt  = r_cnt;
    w_vout = r_vout;
    w_go   = 1'b0;
    w_want = (i_vin > V_HI) ? 1'b0 : ((i_vin < V_LO) ? 1'b1 : r_tgt);
    w_ld   = w_want ? DLY_W'(TPLH_CYC) : DLY_W'(TPHL_CYC);
    case (r_st)
      STEADY, RAMP: begin
        // A new crossing (or a reversal mid-ramp) holds vout and re-arms the delay.
        if (w_want != r_tgt) begin
          w_tgt = w_want;
          if (w_ld == '0) w_go = 1'b1;
          else begin
            w_st  = DELAY;
            w_dly = w_ld;
          end
        end else if (r_st == RAMP) begin
          w_go = 1'b1;
        end
      end
      DELAY: begin
        if (w_want != r_tgt) begin
          w_tgt = ~r_tgt;
          w_st  = STEADY;
        end else if (r_dly <= DLY_W'(1)) begin
          w_go = 1'b1;
        end else begin
          w_dly = r_dly - DLY_W'(1);
        end
      end
      default: w_st = STEADY;
    endcase
    if (w_go) begin
      w_vout = rnm_next_vout(r_vout, w_tgt, w_tgt ? STEP_R : STEP_F, VDD, VSS);
      w_dout = w_tgt;
      w_dly  = '0;
      if (w_vout == (w_tgt ? VDD : VSS)) begin
        w_st = STEADY;
        if (r_cnt != '1) w_cnt = r_cnt + CNT_W'(1);
      end else begin
        w_st = RAMP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= STEADY;
      r_tgt  <= 1'b1;
      r_dout <= 1'b1;
      r_dly  <= '0;
      r_cnt  <= '0;
      r_vout <= VDD;
    end else if (en) begin
      r_st   <= w_st;
      r_tgt  <= w_tgt;
      r_dout <= w_dout;
      r_dly  <= w_dly;
      r_cnt  <= w_cnt;
      r_vout <= w_vout;
    end
  end

  assign o_vout     = r_vout;
  assign o_dout     = r_dout;
  assign o_busy     = (r_st != STEADY);
  assign o_edge_cnt = r_cnt;

endmodule

// File: rtl/rnm_inverter_bank.sv
// N_CH independent clocked RNM inverters sharing clock, reset and enable.
module rnm_inverter_bank
  import rnm_inv_pkg::*;
#(
  parameter int  N_CH      = 4,
  parameter real VDD       = RNM_VDD,
  parameter real VSS       = RNM_VSS,
  parameter real VTH       = RNM_VTH,
  parameter real VHYS      = RNM_VHYS,
  parameter int  TPHL_CYC  = 7,
  parameter int  TPLH_CYC  = 2,
  parameter int  TFALL_CYC = 6,
  parameter int  TRISE_CYC = 7,
  parameter int  CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  real                        vin  [N_CH],
  output real                        vout [N_CH],
  output logic [N_CH-1:0]            dout,
  output logic [N_CH-1:0]            busy,
  output logic [N_CH-1:0][CNT_W-1:0] edge_cnt
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rnm_inv_channel #(
      .VDD(VDD), .VSS(VSS), .VTH(VTH), .VHYS(VHYS),
      .TPHL_CYC(TPHL_CYC), .TPLH_CYC(TPLH_CYC),
      .TFALL_CYC(TFALL_CYC), .TRISE_CYC(TRISE_CYC), .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .i_vin     (vin[g]),
      .o_vout    (vout[g]),
      .o_dout    (dout[g]),
      .o_busy    (busy[g]),
      .o_edge_cnt(edge_cnt[g])
    );
  end

endmodule

// File: tb/tb_rnm_inverter_bank.sv
// Directed scoreboard bench: stimulus queues per-edge expectations, a
// negedge monitor pops and compares them against the bank outputs.
module tb_rnm_inverter_bank;

  localparam real STEP_F = 1.8 / 6.0;
  localparam real STEP_R = 1.8 / 7.0;

  logic            clk = 1'b0;
  logic            rst, en;
  real             vin  [4];
  real             vout [4];
  logic [3:0]      dout, busy;
  logic [3:0][15:0] edge_cnt;

  typedef struct {
    int    cyc;
    int    ch;
    real   v;
    bit    d;
    bit    b;
    int    c;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  rnm_inverter_bank #(.N_CH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .vin(vin), .vout(vout),
    .dout(dout), .busy(busy), .edge_cnt(edge_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
      exp_t e;
      real  dv;
      e  = sb.pop_front();
      dv = vout[e.ch] - e.v;
      n_vec++;
      if (e.cyc != edge_n || dv > 1.0e-9 || dv < -1.0e-9 || dout[e.ch] != e.d ||
          busy[e.ch] != e.b || int'(edge_cnt[e.ch]) != e.c) begin
        n_err++;
        $display("FAIL %s cyc=%0d(now %0d) ch=%0d: got vout=%0.6f dout=%0b busy=%0b cnt=%0d, want vout=%0.6f dout=%0b busy=%0b cnt=%0d",
                 e.nm, e.cyc, edge_n, e.ch, vout[e.ch], dout[e.ch], busy[e.ch],
                 edge_cnt[e.ch], e.v, e.d, e.b, e.c);
      end
    end
  end

  task automatic ex(input int cyc, input int ch, input real v, input bit d,
                    input bit b, input int c, input string nm);
    exp_t e;
    e = '{cyc: cyc, ch: ch, v: v, d: d, b: b, c: c, nm: nm};
    sb.push_back(e);
  endtask

  task automatic ex_range(input int c0, input int c1, input int ch, input real v,
                          input bit d, input bit b, input int c, input string nm);
    for (int k = c0; k <= c1; k++) ex(k, ch, v, d, b, c, nm);
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, edge=%0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 4; i++) vin[i] = 0.0;
    for (int c = 1; c <= 2; c++)
      for (int ch = 0; ch < 4; ch++) ex(c, ch, 1.8, 1, 0, 0, "reset");
    ex_range(3, 22, 0, 1.8, 1, 0, 0, "hold");
    wait_edge(2);
    rst = 1'b0;

    wait_edge(24);
    vin[0] = 1.8;
    ex_range(25, 31, 0, 1.8, 1, 1, 0, "fall_dly");
    for (int i = 1; i <= 6; i++)
      ex(31 + i, 0, 1.8 - i * STEP_F, 0, i < 6, (i == 6) ? 1 : 0, "fall_ramp");
    ex(37, 1, 1.8, 1, 0, 0, "indep_ch1");

    wait_edge(39);
    vin[1] = 1.8;
    ex_range(40, 42, 1, 1.8, 1, 1, 0, "glitch_dly");
    wait_edge(42);
    vin[1] = 0.0;
    ex_range(43, 50, 1, 1.8, 1, 0, 0, "glitch_rej");

    wait_edge(51);
    vin[2] = 0.92;
    ex_range(52, 53, 2, 1.8, 1, 0, 0, "hys_092");
    wait_edge(53);
    vin[2] = 0.88;
    ex_range(54, 56, 2, 1.8, 1, 0, 0, "hys_088");
    wait_edge(57);
    vin[2] = 0.96;
    ex_range(58, 64, 2, 1.8, 1, 1, 0, "hys_096");
    for (int i = 1; i <= 6; i++)
      ex(64 + i, 2, 1.8 - i * STEP_F, 0, i < 6, (i == 6) ? 1 : 0, "hys_ramp");

    wait_edge(74);
    vin[3] = 1.8;
    ex_range(75, 81, 3, 1.8, 1, 1, 0, "rev_dly");
    ex(82, 3, 1.8 - STEP_F, 0, 1, 0, "rev_ramp");
    ex(83, 3, 1.8 - 2.0 * STEP_F, 0, 1, 0, "rev_ramp");
    wait_edge(83);
    vin[3] = 0.0;
    ex_range(84, 85, 3, 1.2, 0, 1, 0, "rev_hold");
    ex(86, 3, 1.2 + STEP_R, 1, 1, 0, "rev_rise");
    ex(87, 3, 1.2 + 2.0 * STEP_R, 1, 1, 0, "rev_rise");
    ex(88, 3, 1.8, 1, 0, 1, "rev_clamp");

    wait_edge(91);
    vin[1] = 1.8;
    ex_range(92, 94, 1, 1.8, 1, 1, 0, "en_dly");
    wait_edge(94);
    en     = 1'b0;
    vin[2] = 0.0;
    for (int c = 95; c <= 99; c++) begin
      ex(c, 0, 0.0, 0, 0, 1, "indep_ch0");
      ex(c, 1, 1.8, 1, 1, 0, "en_frz");
      ex(c, 2, 0.0, 0, 0, 1, "en_frz_ch2");
    end
    wait_edge(99);
    en = 1'b1;
    for (int c = 100; c <= 103; c++) begin
      ex(c, 1, 1.8, 1, 1, 0, "en_resume");
      if (c < 102) ex(c, 2, 0.0, 0, 1, 1, "ch2_rise_dly");
      else         ex(c, 2, (c - 101) * STEP_R, 1, 1, 1, "ch2_rise");
    end
    ex(104, 1, 1.8 - STEP_F, 0, 1, 0, "en_step");
    ex(105, 1, 1.8 - 2.0 * STEP_F, 0, 1, 0, "en_step");

    wait_edge(105);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) vin[i] = 0.0;
    for (int ch = 0; ch < 4; ch++) ex(106, ch, 1.8, 1, 0, 0, "rst_ramp");
    wait_edge(106);
    rst = 1'b0;
    for (int ch = 0; ch < 4; ch++) ex(108, ch, 1.8, 1, 0, 0, "post_rst");

    wait_edge(110);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: cyc=%0d ch=%0d never checked", e.nm, e.cyc, e.ch);
    end
    n_vec++;
    if (vout[0] > 1.8 + 1.0e-9 || vout[0] < 1.8 - 1.0e-9) begin
      n_err++;
      $display("FAIL final ch0 vout=%0.6f", vout[0]);
    end
    n_vec++;
    if (vout[1] > 1.8 + 1.0e-9 || vout[1] < 1.8 - 1.0e-9) begin
      n_err++;
      $display("FAIL final ch1 vout=%0.6f", vout[1]);
    end
    n_vec++;
    if (vout[2] > 1.8 + 1.0e-9 || vout[2] < 1.8 - 1.0e-9) begin
      n_err++;
      $display("FAIL final ch2 vout=%0.6f", vout[2]);
    end
    n_vec++;
    if (vout[3] > 1.8 + 1.0e-9 || vout[3] < 1.8 - 1.0e-9) begin
      n_err++;
      $display("FAIL final ch3 vout=%0.6f", vout[3]);
    end
    n_vec++;
    if (dout !== 4'hF) begin
      n_err++;
      $display("FAIL final dout=%b", dout);
    end
    n_vec++;
    if (busy !== 4'h0) begin
      n_err++;
      $display("FAIL final busy=%b", busy);
    end
    n_vec++;
    if (edge_cnt !== '0) begin
      n_err++;
      $display("FAIL final edge_cnt=%h", edge_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
